// File: rtl/ccd_line_rx.sv
// rtl/ccd_line_rx.sv - CCD line receiver: dummy/black/buffer/active sequencing, black level, FWFT pixel FIFO.
// Optional build macro CCD_RX_OB_CLAMP_EN subtracts the black level from active samples.
module ccd_line_rx #(
    parameter int DW     = 14,
    parameter int NDUM   = 12,
    parameter int NBLA   = 26,
    parameter int NBUF   = 16,
    parameter int NACT   = 2436,
    parameter int FDEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic          vact,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sol,
    output logic          m_eol,
    output logic [DW-1:0] ob_level,
    output logic          overflow
);
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = $clog2(NDUM + NBLA + NBUF + NACT + 1);

    typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_BLACK, S_BUFFER, S_ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [DW+3:0]   acc_q, acc_d;
    logic [DW-1:0]   ob_q;
    logic            ovf_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [DW+1:0]   mem_q [FDEPTH];
    logic [DW+1:0]   head;

    logic            start, last, in_win, wr_req, wr_en, rd, full, empty;
    logic            tag_sol, tag_eol;
    logic [DW-1:0]   wr_data;

    always_comb begin
        start   = line_start && vact;
        last    = 1'b0;
        state_d = state_q;
        case (state_q)
            S_DUMMY:  begin last = (cnt_q == CW'(NDUM - 1)); state_d = S_BLACK;  end
            S_BLACK:  begin last = (cnt_q == CW'(NBLA - 1)); state_d = S_BUFFER; end
            S_BUFFER: begin last = (cnt_q == CW'(NBUF - 1)); state_d = S_ACTIVE; end
            S_ACTIVE: begin last = (cnt_q == CW'(NACT - 1)); state_d = S_IDLE;   end
            default:  begin last = 1'b0;                     state_d = S_IDLE;   end
        endcase
        // Only the central 16 black samples contribute; the edges of the black region are unreliable.
        in_win  = (state_q == S_BLACK) && (cnt_q >= CW'(4)) && (cnt_q <= CW'(19));
        acc_d   = acc_q + ((adc_valid && in_win) ? {4'b0000, adc_data} : '0);
        wr_req  = !start && adc_valid && (state_q == S_ACTIVE);
        tag_sol = (cnt_q == '0);
        tag_eol = (cnt_q == CW'(NACT - 1));
`ifdef CCD_RX_OB_CLAMP_EN
        wr_data = (adc_data > ob_q) ? (adc_data - ob_q) : '0;
`else
        wr_data = adc_data;
`endif
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd      = !empty && m_ready;
        wr_en   = wr_req && (!full || rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ob_q     <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (start) begin
                state_q <= S_DUMMY;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else if (adc_valid && state_q != S_IDLE) begin
                acc_q <= acc_d;
                if (last) begin
                    state_q <= state_d;
                    cnt_q   <= '0;
                    if (state_q == S_BLACK) ob_q <= acc_d[DW+3:4];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_req && full && !rd) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {tag_sol, tag_eol, wr_data};
    end

    // Outputs are gated by rst so they read as idle for the whole reset cycle, not just after it.
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign m_valid  = !empty && !rst;
    assign m_data   = head[DW-1:0];
    assign m_sol    = m_valid && head[DW+1];
    assign m_eol    = m_valid && head[DW];
    assign ob_level = rst ? '0 : ob_q;
    assign overflow = ovf_q && !rst;
endmodule

// File: tb/tb_ccd_line_rx.sv
// tb/tb_ccd_line_rx.sv - self-checking bench for ccd_line_rx against a line-level reference model.
module tb_ccd_line_rx;
    localparam int DW = 14, NDUM = 12, NBLA = 26, NBUF = 16, NACT = 2436;
    localparam int P0 = NDUM + NBLA + NBUF, LINE = P0 + NACT;

    logic          clk = 1'b0, rst = 1'b1, line_start = 1'b0, vact = 1'b0;
    logic          adc_valid = 1'b0, m_ready = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic [DW-1:0] m_data, ob_level;
    logic          m_valid, m_sol, m_eol, overflow;

    int checks = 0, errors = 0;
    logic [DW+1:0] got_q[$], exp_q[$];
    logic [DW-1:0] exp_ob = '0;

    ccd_line_rx dut (
        .clk(clk), .rst(rst), .line_start(line_start), .vact(vact),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sol(m_sol), .m_eol(m_eol), .ob_level(ob_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_valid && m_ready) got_q.push_back({m_sol, m_eol, m_data});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (40) tick();
    endtask

    // Reference: a line is a list of samples by position; pixels are positions P0..LINE-1.
    task automatic model_line(input logic [DW-1:0] s[$]);
        int unsigned sum;
        logic [DW-1:0] v;
        sum = 0;
        for (int k = 4; k <= 19; k++) sum += s[NDUM + k];
        exp_ob = DW'(sum / 16);
        exp_q.delete();
        for (int i = 0; i < NACT; i++) begin
            v = s[P0 + i];
`ifdef CCD_RX_OB_CLAMP_EN
            v = (v > exp_ob) ? v - exp_ob : '0;
`endif
            exp_q.push_back({(i == 0), (i == NACT - 1), v});
        end
    endtask

    task automatic idx_line(output logic [DW-1:0] s[$]);
        s.delete();
        for (int i = 0; i < LINE; i++) s.push_back(DW'(i));
    endtask

    task automatic rand_line(output logic [DW-1:0] s[$]);
        s.delete();
        for (int i = 0; i < LINE; i++) s.push_back(DW'($urandom));
    endtask

    task automatic drive(input logic [DW-1:0] s[$], input bit start, input bit gaps);
        if (start) begin
            line_start = 1'b1; vact = 1'b1; adc_valid = 1'b0;
            tick();
            line_start = 1'b0; vact = 1'($urandom_range(0, 1));
        end
        foreach (s[i]) begin
            adc_valid = 1'b1; adc_data = s[i];
            tick();
            if (gaps) begin
                adc_valid = 1'b0; adc_data = DW'($urandom);
                tick();
            end
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b expected 0", m_valid); end
        checks++; if (m_sol !== 1'b0 || m_eol !== 1'b0) begin errors++; $display("FAIL reset_tags got %b%b expected 00", m_sol, m_eol); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
        checks++; if (ob_level !== '0) begin errors++; $display("FAIL reset_ob_level got %h expected 0", ob_level); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal_line();
        logic [DW-1:0] s[$];
        idx_line(s); model_line(s);
        m_ready = 1'b1; got_q.delete();
        drive(s, 1'b1, 1'b0); drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL normal_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL normal_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ob_level !== exp_ob) begin errors++; $display("FAIL normal_ob got %h expected %h", ob_level, exp_ob); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL normal_overflow got %b expected 0", overflow); end
    endtask

    task automatic test_random_lines();
        logic [DW-1:0] s[$];
        for (int n = 0; n < 2; n++) begin
            rand_line(s); model_line(s);
            got_q.delete();
            drive(s, 1'b1, 1'b0); drain();
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d expected %0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
            end
            checks++; if (ob_level !== exp_ob) begin errors++; $display("FAIL random_ob got %h expected %h", ob_level, exp_ob); end
        end
    endtask

    task automatic test_black_level();
        logic [DW-1:0] s[$];
        rand_line(s);
        for (int k = 0; k < NBLA; k++) s[NDUM + k] = (k >= 4 && k <= 19) ? DW'(14'h100) : DW'(14'h3FFF);
        s[P0] = DW'(14'h0F0); s[P0 + 1] = DW'(14'h180);
        model_line(s);
        got_q.delete();
        drive(s[0:P0-9], 1'b1, 1'b0);
        checks++; if (ob_level !== 14'h100) begin errors++; $display("FAIL black_ob got %h expected 100", ob_level); end
        drive(s[P0-8:LINE-1], 1'b0, 1'b0); drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL black_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL black_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] s1[$], s2[$];
        logic [DW-1:0] prev_ob;
        prev_ob = exp_ob;
        rand_line(s1); rand_line(s2);
        got_q.delete();
        drive(s1[0:29], 1'b1, 1'b0);
        drive(s2[0:19], 1'b1, 1'b0);
        checks++; if (ob_level !== prev_ob) begin errors++; $display("FAIL abort_ob_held got %h expected %h", ob_level, prev_ob); end
        model_line(s2);
        drive(s2[20:LINE-1], 1'b0, 1'b0); drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ob_level !== exp_ob) begin errors++; $display("FAIL abort_ob_new got %h expected %h", ob_level, exp_ob); end
    endtask

    task automatic test_gating();
        logic [DW-1:0] s[$];
        rand_line(s);
        got_q.delete();
        line_start = 1'b1; vact = 1'b0;
        tick();
        line_start = 1'b0;
        drive(s, 1'b0, 1'b0); drain();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL gate_vact0 got %0d pixels expected 0", got_q.size()); end
        model_line(s);
        got_q.delete();
        drive(s, 1'b1, 1'b1); drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gate_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gate_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] s[$];
        idx_line(s); model_line(s);
        got_q.delete(); m_ready = 1'b0;
        drive(s, 1'b1, 1'b0);
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b expected 1", overflow); end
        checks++; if ({m_valid, m_sol, m_eol, m_data} !== {1'b1, exp_q[0]}) begin
            errors++; $display("FAIL bp_head got %b%b%b %h expected 1 %h", m_valid, m_sol, m_eol, m_data, exp_q[0]); end
        m_ready = 1'b1; drain();
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL bp_count got %0d expected 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s[$];
        idx_line(s);
        got_q.delete(); m_ready = 1'b0;
        drive(s[0:P0+7], 1'b1, 1'b0);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b expected 1", m_valid); end
        rst = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", m_valid); end
        rst = 1'b0; m_ready = 1'b1;
        drive(s[0:199], 1'b0, 1'b0); drain();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_no_pixels got %0d expected 0", got_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got %b expected 0", overflow); end
        checks++; if (ob_level !== '0) begin errors++; $display("FAIL rmid_ob got %h expected 0", ob_level); end
        model_line(s);
        drive(s, 1'b1, 1'b0); drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_pixel[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_normal_line();
        test_random_lines();
        test_black_level();
        test_abort();
        test_gating();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
